// File: rtl/seq_det_pkg.sv
// Shared definitions for the seq_det sequence detector.
// Holds the one-hot state encoding and the idx width helper.
package seq_det_pkg;

    localparam int unsigned ST_W = 5;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE  = 5'b00001;
    localparam state_t ST_ARM   = 5'b00010;
    localparam state_t ST_TRACK = 5'b00100;
    localparam state_t ST_HIT   = 5'b01000;
    localparam state_t ST_LOCK  = 5'b10000;

    // Bits needed to hold a match count of 0..seq_len inclusive.
    function automatic int unsigned idx_width(input int unsigned seq_len);
        return $clog2(seq_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_tmo.sv
// Inter-symbol idle counter for seq_det_fsm.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   inc         : advance the idle count by one
//   clr         : zero the count (wins over inc)
//   limit       : idle limit; 0 disables expiry
//   expired_c   : combinational, high when this idle cycle reaches the limit
module seq_det_tmo #(
    parameter int unsigned TMO_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic [TMO_W-1:0] limit,
    output logic             expired_c
);

    logic [TMO_W-1:0] count;

    // Idle-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= TMO_W'(count + TMO_W'(1));
        end
    end

    // Expiry looks one step ahead so the transition happens on the limit-th idle cycle.
    assign expired_c = (limit != '0) && (TMO_W'(count + TMO_W'(1)) == limit);

endmodule

// File: rtl/seq_det_fsm.sv
// Moore sequence detector: watches a valid-qualified symbol stream for a
// runtime-programmable pattern, with inter-symbol timeout and optional lock.
// Optional feature macro: SEQ_DET_HITCNT_EN adds the saturating hit_cnt port.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   en           : detector enable; low forces IDLE
//   clr          : sync clear; exits LOCK, zeroes counters
//   sym_vld, sym : symbol strobe and value
//   pattern      : element k at pattern[k*SYM_W +: SYM_W], element 0 first
//   tmo_limit    : max idle cycles between symbols in TRACK; 0 disables
//   lock_on_hit  : 1 sends HIT to LOCK, 0 sends HIT to ARM
//   busy/hit/locked : state decodes (not IDLE / HIT / LOCK)
//   idx          : symbols matched so far
//   hit_cnt      : saturating hit count (macro builds only)
module seq_det_fsm
    import seq_det_pkg::*;
#(
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned SEQ_LEN = 4,
    parameter int unsigned TMO_W   = 8
`ifdef SEQ_DET_HITCNT_EN
    ,
    parameter int unsigned CNT_W   = 8
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       sym_vld,
    input  logic [SYM_W-1:0]           sym,
    input  logic [SEQ_LEN*SYM_W-1:0]   pattern,
    input  logic [TMO_W-1:0]           tmo_limit,
    input  logic                       lock_on_hit,
    output logic                       busy,
    output logic                       hit,
    output logic                       locked,
    output logic [idx_width(SEQ_LEN)-1:0] idx
`ifdef SEQ_DET_HITCNT_EN
    ,
    output logic [CNT_W-1:0]           hit_cnt
`endif
);

    localparam int unsigned IDX_W = idx_width(SEQ_LEN);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic [SYM_W-1:0]   exp_sym;
    logic [SYM_W-1:0]   first_sym;
    logic               tmo_inc;
    logic               tmo_clr;
    logic               tmo_expired_c;

    seq_det_tmo #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (tmo_inc),
        .clr       (tmo_clr),
        .limit     (tmo_limit),
        .expired_c (tmo_expired_c)
    );

    // Pattern element expected at the current match position.
    always_comb begin
        first_sym = pattern[SYM_W-1:0];
        exp_sym   = pattern[SYM_W-1:0];
        for (int k = 0; k < int'(SEQ_LEN); k++) begin
            if (idx == IDX_W'(k)) begin
                exp_sym = pattern[k*SYM_W +: SYM_W];
            end
        end
    end

    // Next-state, idx and timeout control.
    always_comb begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
        tmo_inc   = 1'b0;
        tmo_clr   = 1'b1;

        if (!en) begin
            state_nxt = ST_IDLE;
        end else if (clr) begin
            state_nxt = ST_ARM;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_ARM;
                end
                ST_ARM: begin
                    state_nxt = ST_ARM;
                    if (sym_vld && (sym == first_sym)) begin
                        idx_nxt   = IDX_W'(1);
                        state_nxt = (SEQ_LEN == 1) ? ST_HIT : ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    state_nxt = ST_TRACK;
                    idx_nxt   = idx;
                    if (sym_vld) begin
                        if (sym == exp_sym) begin
                            idx_nxt = IDX_W'(idx + IDX_W'(1));
                            if (idx == IDX_W'(SEQ_LEN - 1)) begin
                                state_nxt = ST_HIT;
                            end
                        end else if (sym == first_sym) begin
                            // Simple restart on the first element, no overlap search.
                            idx_nxt = IDX_W'(1);
                        end else begin
                            idx_nxt   = '0;
                            state_nxt = ST_ARM;
                        end
                    end else if (tmo_expired_c) begin
                        idx_nxt   = '0;
                        state_nxt = ST_ARM;
                    end else begin
                        tmo_inc = 1'b1;
                        tmo_clr = 1'b0;
                    end
                end
                ST_HIT: begin
                    state_nxt = lock_on_hit ? ST_LOCK : ST_ARM;
                end
                ST_LOCK: begin
                    state_nxt = ST_LOCK;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register and state-decoded outputs, all loaded from the same next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            busy   <= 1'b0;
            hit    <= 1'b0;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            busy   <= (state_nxt != ST_IDLE);
            hit    <= (state_nxt == ST_HIT);
            locked <= (state_nxt == ST_LOCK);
        end
    end

`ifdef SEQ_DET_HITCNT_EN
    // Saturating hit counter; survives en==0, cleared only by clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (en && clr) begin
            hit_cnt <= '0;
        end else if ((state_nxt == ST_HIT) && (hit_cnt != '1)) begin
            hit_cnt <= CNT_W'(hit_cnt + CNT_W'(1));
        end
    end
`endif

endmodule
